// File: rtl/karatsuba_mult_seq.sv
// Sequential 8x8 unsigned Karatsuba multiplier: three partial products (A, B, M)
// on one time-shared 5x5 shift-add unit, then combined into a 16-bit product.
module karatsuba_mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  X,
    input  logic [7:0]  Y,
    input  logic [4:0]  D,
    input  logic [4:0]  E,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] P,
    output logic        factor_err,
    output logic        busy
);

    localparam int DATA_W = 8;
    localparam int COEF_W = 5;
    localparam int ACC_W  = 2 * COEF_W;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_B   = 3'd1,
        MUL_A   = 3'd2,
        MUL_M   = 3'd3,
        COMBINE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   x_r;
    logic [DATA_W-1:0]   y_r;
    logic [COEF_W-1:0]   d_r;
    logic [COEF_W-1:0]   e_r;
    logic                ferr_r;
    logic [2:0]          step;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic [ACC_W-1:0]    m_r;
    logic [COEF_W-1:0]   mcand;
    logic [COEF_W-1:0]   mplr;

    // One multiplier bit per call: add the shifted multiplicand when that bit is set.
    function automatic logic [ACC_W-1:0] shift_add_step(
        input logic [ACC_W-1:0]  acc_in,
        input logic [COEF_W-1:0] cand,
        input logic [COEF_W-1:0] plr,
        input logic [2:0]        idx
    );
        logic [ACC_W-1:0] addend;
        addend = plr[idx] ? ({{(ACC_W-COEF_W){1'b0}}, cand} << idx) : '0;
        return acc_in + addend;
    endfunction

    // Karatsuba recombination; C wraps in 10 bits and P wraps in 16 bits by design.
    function automatic logic [PROD_W-1:0] combine_product(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [ACC_W-1:0]  m
    );
        logic [ACC_W-1:0] c;
        c = m - {2'b00, a} - {2'b00, b};
        return {a, 8'h00} + {2'b00, c, 4'h0} + {8'h00, b};
    endfunction

    function automatic logic factor_mismatch(
        input logic [DATA_W-1:0] v,
        input logic [COEF_W-1:0] f
    );
        logic [COEF_W-1:0] nib_sum;
        nib_sum = {1'b0, v[7:4]} + {1'b0, v[3:0]};
        return f != nib_sum;
    endfunction

    always_comb begin
        mcand = '0;
        mplr  = '0;
        case (state)
            MUL_B: begin
                mcand = {1'b0, x_r[3:0]};
                mplr  = {1'b0, y_r[3:0]};
            end
            MUL_A: begin
                mcand = {1'b0, x_r[7:4]};
                mplr  = {1'b0, y_r[7:4]};
            end
            MUL_M: begin
                mcand = d_r;
                mplr  = e_r;
            end
            default: ;
        endcase
        acc_next = shift_add_step(acc, mcand, mplr, step);
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x_r        <= '0;
            y_r        <= '0;
            d_r        <= '0;
            e_r        <= '0;
            ferr_r     <= 1'b0;
            step       <= '0;
            acc        <= '0;
            a_r        <= '0;
            b_r        <= '0;
            m_r        <= '0;
            P          <= '0;
            factor_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r    <= X;
                        y_r    <= Y;
                        d_r    <= D;
                        e_r    <= E;
                        ferr_r <= factor_mismatch(X, D) | factor_mismatch(Y, E);
                        step   <= '0;
                        acc    <= '0;
                        state  <= MUL_B;
                    end
                end
                MUL_B, MUL_A, MUL_M: begin
                    // Step 4 is the last bit: bank the result and restart the unit.
                    if (step == 3'd4) begin
                        step <= '0;
                        acc  <= '0;
                        case (state)
                            MUL_B: begin
                                b_r   <= acc_next[7:0];
                                state <= MUL_A;
                            end
                            MUL_A: begin
                                a_r   <= acc_next[7:0];
                                state <= MUL_M;
                            end
                            default: begin
                                m_r   <= acc_next;
                                state <= COMBINE;
                            end
                        endcase
                    end else begin
                        step <= step + 3'd1;
                        acc  <= acc_next;
                    end
                end
                COMBINE: begin
                    P          <= combine_product(a_r, b_r, m_r);
                    factor_err <= ferr_r;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_mult_seq.sv
// Bench for karatsuba_mult_seq: directed cases, backpressure, mid-run reset and
// random operands checked against a plain-arithmetic product model.
module tb_karatsuba_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  X;
    logic [7:0]  Y;
    logic [4:0]  D;
    logic [4:0]  E;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] P;
    logic        factor_err;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    karatsuba_mult_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .X          (X),
        .Y          (Y),
        .D          (D),
        .E          (E),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .P          (P),
        .factor_err (factor_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_p(input logic [7:0] x, input logic [7:0] y);
        int prod;
        prod = int'(x) * int'(y);
        return prod[15:0];
    endfunction

    function automatic logic model_ferr(input logic [7:0] x, input logic [7:0] y,
                                        input logic [4:0] d, input logic [4:0] e);
        int sx;
        int sy;
        sx = int'(x[7:4]) + int'(x[3:0]);
        sy = int'(y[7:4]) + int'(y[3:0]);
        return (int'(d) != sx) || (int'(e) != sy);
    endfunction

    // Present one operand set in IDLE; returns after the accepting edge.
    task automatic start_txn(input logic [7:0] x, input logic [7:0] y,
                             input logic [4:0] d, input logic [4:0] e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        X = x; Y = y; D = d; E = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until out_valid is visible.
    task automatic wait_result(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (!out_valid && (in_ready || !busy)) chk("busy_during_compute", {31'b0, busy & ~in_ready}, 1);
        end while (!out_valid && edges < 40);
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic run_txn(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [4:0] d, input logic [4:0] e, input bit chk_lat);
        int edges;
        logic ferr_exp;
        ferr_exp = model_ferr(x, y, d, e);
        start_txn(x, y, d, e);
        wait_result(edges);
        // out_valid first visible after 16 edges, i.e. sampled high at edge 17.
        if (chk_lat) chk({tag, "_latency"}, edges, 16);
        chk({tag, "_ferr"}, {31'b0, factor_err}, {31'b0, ferr_exp});
        if (!ferr_exp) chk({tag, "_P"}, {16'b0, P}, {16'b0, model_p(x, y)});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (chk_lat) chk({tag, "_idle_after"}, {30'b0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        int edges;
        logic [15:0] p_hold;
        logic        f_hold;
        logic [7:0]  rx, ry;
        logic [4:0]  rd, re;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        X = '0; Y = '0; D = '0; E = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_P", {16'b0, P}, 0);
        chk("rst_ferr", {31'b0, factor_err}, 0);
        rst = 1'b0;

        run_txn("basic", 8'h65, 8'h86, 5'h0B, 5'h0E, 1'b1);
        run_txn("f0f0", 8'hF0, 8'hF0, 5'h0F, 5'h0F, 1'b1);
        run_txn("ffff", 8'hFF, 8'hFF, 5'h1E, 5'h1E, 1'b1);
        run_txn("zero", 8'h00, 8'hAB, 5'h00, 5'h15, 1'b1);
        run_txn("one", 8'h01, 8'h01, 5'h01, 5'h01, 1'b1);
        run_txn("bad_d", 8'h65, 8'h86, 5'h00, 5'h0E, 1'b1);
        chk("bad_d_flag_direct", {31'b0, factor_err}, 1);

        // Backpressure, with an ignored in_valid pulse and a DONE-state collision.
        out_ready = 1'b0;
        start_txn(8'h3C, 8'hA7, 5'h0F, 5'h11);
        wait_result(edges);
        chk("bp_P", {16'b0, P}, {16'b0, model_p(8'h3C, 8'hA7)});
        p_hold = P;
        f_hold = factor_err;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                X = 8'h11; Y = 8'h22; D = 5'h02; E = 5'h04; in_valid = 1'b1;
            end
            if (i == 4) in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold", {13'b0, out_valid, in_ready, factor_err, P},
                {13'b0, 1'b1, 1'b0, f_hold, p_hold});
        end
        X = 8'h11; Y = 8'h22; D = 5'h02; E = 5'h04;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_release", {29'b0, in_ready, busy, out_valid}, 32'b100);
        run_txn("after_bp", 8'h11, 8'h22, 5'h02, 5'h04, 1'b1);

        // Reset at edge 8, i.e. in MUL_A.
        start_txn(8'h65, 8'h86, 5'h0B, 5'h0E);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst", {12'b0, in_ready, busy, out_valid, factor_err, P}, {12'b0, 4'b1000, 16'h0000});
        run_txn("post_rst", 8'h65, 8'h86, 5'h0B, 5'h0E, 1'b1);

        for (int i = 0; i < 20; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rd = {1'b0, rx[7:4]} + {1'b0, rx[3:0]};
            re = {1'b0, ry[7:4]} + {1'b0, ry[3:0]};
            if ($urandom_range(0, 4) == 0) rd = rd ^ 5'(1 + $urandom_range(0, 30));
            if ($urandom_range(0, 4) == 0) re = re ^ 5'(1 + $urandom_range(0, 30));
            run_txn("rand", rx, ry, rd, re, (i % 4) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
